// File: rtl/tpu_pkg.sv
// Shared TPU definitions for the accumulator drain path.
//   N_COLS / ACC_W / ACC_ADDR_W : accumulator geometry
//   RD_LAT / FIFO_DEPTH         : default read latency and output buffering
//   acc_line_t                  : one full accumulator line, column 0 in the LSBs
//   drain_state_t               : drain controller states
package tpu_pkg;

    localparam int unsigned N_COLS     = 32;
    localparam int unsigned ACC_W      = 32;
    localparam int unsigned ACC_ADDR_W = 7;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [N_COLS*ACC_W-1:0] acc_line_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO buffering accumulator lines returned by the read path.
//   clk_i / rst_ni : clock, asynchronous active-low reset (empties the FIFO, clears storage)
//   push_i, data_i : write one entry (ignored when full unless popping in the same cycle)
//   pop_i          : remove the head entry (ignored when empty)
//   data_o         : head entry
//   count_o        : current occupancy
//   empty_o        : occupancy is zero
module drain_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop, full;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // Storage is cleared so the output line reads as zero straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/accumulator_drain_unit.sv
// Accumulator drain unit: after start_i, reads lines_i accumulator lines from start_addr_i
// (one address per cycle, wrapping modulo 2^AddrW) and streams them out over valid/ready.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   start_i, start_addr_i,
//   lines_i                    : drain request (ignored while busy_o)
//   acc_read_o, acc_addr_rd_o  : registered accumulator read strobe / address
//   acc_data_i                 : read data, valid RdLat cycles after acc_read_o
//   out_valid_o, out_ready_i,
//   out_data_o, out_last_o     : output stream, out_last_o on the final line
//   busy_o, done_o             : drain in progress / 1-cycle pulse after last line accepted
// Build option: define DRAIN_RELU_EN to clamp negative columns of out_data_o to zero.
module accumulator_drain_unit
    import tpu_pkg::*;
#(
    parameter int unsigned NCols     = N_COLS,
    parameter int unsigned AccW      = ACC_W,
    parameter int unsigned AddrW     = ACC_ADDR_W,
    parameter int unsigned RdLat     = RD_LAT,
    parameter int unsigned FifoDepth = FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [AddrW-1:0]      start_addr_i,
    input  logic [15:0]           lines_i,
    output logic                  acc_read_o,
    output logic [AddrW-1:0]      acc_addr_rd_o,
    input  logic [NCols*AccW-1:0] acc_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NCols*AccW-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned LineW = NCols * AccW;
    localparam int unsigned CntW  = $clog2(FifoDepth + 1);

    drain_state_t     state_q, state_d;
    logic             read_q, read_d;
    logic [AddrW-1:0] rd_addr_q, rd_addr_d, next_addr_q, next_addr_d;
    logic [15:0]      issued_q, issued_d, lines_q, lines_d, beat_q, beat_d;
    logic             done_q, done_d;
    logic [RdLat-1:0] tag_q;
    logic [LineW-1:0] fifo_head, out_line;
    logic [CntW-1:0]  fifo_count;
    logic             fifo_empty, pop, credit_ok;
    logic [15:0]      outstanding;

    assign out_valid_o   = !fifo_empty;
    assign pop           = out_valid_o && out_ready_i;
    assign out_last_o    = out_valid_o && (state_q != IDLE) && (beat_q == lines_q - 16'd1);
    assign acc_read_o    = read_q;
    assign acc_addr_rd_o = rd_addr_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

    // Lines committed but not yet gone: read strobe in flight, tagged returns, FIFO entries.
    // A pop this cycle frees a slot in time for the read issued now.
    always_comb begin
        outstanding = 16'(read_q) + 16'(fifo_count);
        for (int i = 0; i < int'(RdLat); i++) outstanding = outstanding + 16'(tag_q[i]);
        if (pop) outstanding = outstanding - 16'd1;
    end
    assign credit_ok = (outstanding < 16'(FifoDepth));

    always_comb begin
        state_d     = state_q;
        read_d      = 1'b0;
        rd_addr_d   = rd_addr_q;
        next_addr_d = next_addr_q;
        issued_d    = issued_q;
        lines_d     = lines_q;
        beat_d      = pop ? beat_q + 16'd1 : beat_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (lines_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read is issued straight from the start cycle.
                        lines_d     = lines_i;
                        read_d      = 1'b1;
                        rd_addr_d   = start_addr_i;
                        next_addr_d = start_addr_i + AddrW'(1);
                        issued_d    = 16'd1;
                        beat_d      = 16'd0;
                        state_d     = (lines_i == 16'd1) ? FLUSH : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credit_ok) begin
                    read_d      = 1'b1;
                    rd_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + AddrW'(1);
                    issued_d    = issued_q + 16'd1;
                    if (issued_q + 16'd1 == lines_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && out_last_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            rd_addr_q   <= '0;
            next_addr_q <= '0;
            issued_q    <= '0;
            lines_q     <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            rd_addr_q   <= rd_addr_d;
            next_addr_q <= next_addr_d;
            issued_q    <= issued_d;
            lines_q     <= lines_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
        end
    end

    // Valid tag follows each read through the accumulator latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= read_q;
            for (int i = 1; i < int'(RdLat); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    drain_fifo #(
        .Depth (FifoDepth),
        .Width (LineW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tag_q[RdLat-1]),
        .data_i  (acc_data_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        out_line = fifo_head;
`ifdef DRAIN_RELU_EN
        for (int c = 0; c < int'(NCols); c++) begin
            if (fifo_head[c*AccW + AccW - 1]) out_line[c*AccW +: AccW] = '0;
        end
`else
`endif
    end

    assign out_data_o = out_line;

endmodule

// File: tb/tb_accumulator_drain_unit.sv
module tb_accumulator_drain_unit;
    localparam int LINE_W = 1024;
    localparam int RD_LAT = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [6:0]        start_addr_i;
    logic [15:0]       lines_i;
    logic              acc_read_o;
    logic [6:0]        acc_addr_rd_o;
    logic [LINE_W-1:0] acc_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [LINE_W-1:0] out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;

    int n_cmp = 0;
    int n_err = 0;
    int reads_seen = 0;
    int n_beats = 0;
    int n_done = 0;

    logic [6:0]        exp_addr [$];
    logic [LINE_W-1:0] exp_data [$];
    logic              exp_last [$];

    always #5 clk_i = ~clk_i;

    accumulator_drain_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .start_addr_i  (start_addr_i),
        .lines_i       (lines_i),
        .acc_read_o    (acc_read_o),
        .acc_addr_rd_o (acc_addr_rd_o),
        .acc_data_i    (acc_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Accumulator contents: column c of line a is +-(a*64+c); line 9 holds -7 / +9 in cols 0/1.
    function automatic logic [LINE_W-1:0] mem_line(input logic [6:0] a);
        logic [LINE_W-1:0] l;
        int v;
        for (int c = 0; c < 32; c++) begin
            v = int'(a) * 64 + c;
            if (c % 2 == 1) v = -v;
            if (a == 7'd9 && c == 0) v = -7;
            if (a == 7'd9 && c == 1) v = 9;
            l[c*32 +: 32] = v;
        end
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] exp_line(input logic [6:0] a);
        logic [LINE_W-1:0] l;
        l = mem_line(a);
`ifdef DRAIN_RELU_EN
        for (int c = 0; c < 32; c++) if (l[c*32 + 31]) l[c*32 +: 32] = '0;
`endif
        return l;
    endfunction

    // Accumulator read model with RD_LAT cycles of latency; junk when not returning a read.
    logic       pipe_v [RD_LAT];
    logic [6:0] pipe_a [RD_LAT];
    always @(posedge clk_i) begin
        pipe_v[0] <= acc_read_o;
        pipe_a[0] <= acc_addr_rd_o;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    always_comb begin
        acc_data_i = {32{32'hDEAD_BEEF}};
        if (pipe_v[RD_LAT-1] === 1'b1) acc_data_i = mem_line(pipe_a[RD_LAT-1]);
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: reads checked against expected addresses, accepted beats against data.
    always @(negedge clk_i) begin
        #1;
        if (rst_ni) begin
            if (acc_read_o) begin
                reads_seen++;
                if (exp_addr.size() == 0) check("spurious_read", 1, 0);
                else check("rd_addr", acc_addr_rd_o, exp_addr.pop_front());
            end
            if (out_valid_o && out_ready_i) begin
                n_beats++;
                if (exp_data.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("beat_data", out_data_o, exp_data.pop_front());
                    check("beat_last", out_last_o, exp_last.pop_front());
                end
            end
            if (done_o) n_done++;
        end
    end

    task automatic do_start(input logic [6:0] a, input logic [15:0] n, input bit expect_lines);
        start_i      = 1'b1;
        start_addr_i = a;
        lines_i      = n;
        if (expect_lines) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr.push_back(7'(int'(a) + i));
                exp_data.push_back(exp_line(7'(int'(a) + i)));
                exp_last.push_back(i == int'(n) - 1);
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        check(tag, seen, 1);
        @(negedge clk_i);
    endtask

    task automatic wait_beats(input int n);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (n_beats >= n) begin
                ok = 1;
                break;
            end
        end
        check("beats_timeout", ok, 1);
    endtask

    initial begin
        int r0, d0, b0;
        logic [LINE_W-1:0] held;

        rst_ni       = 1'b0;
        start_i      = 1'b0;
        start_addr_i = '0;
        lines_i      = '0;
        out_ready_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_read", acc_read_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_data", out_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: exact cycle timing, addr 5, 3 lines
        do_start(7'd5, 16'd3, 1);
        for (int k = 1; k <= 7; k++) begin
            check("t1_read", acc_read_o, (k <= 3));
            if (k <= 3) check("t1_addr", acc_addr_rd_o, 4 + k);
            check("t1_valid", out_valid_o, (k >= 4 && k <= 6));
            check("t1_last", out_last_o, (k == 6));
            check("t1_done", done_o, (k == 7));
            check("t1_busy", busy_o, (k <= 6));
            @(negedge clk_i);
        end
        check("t1_queue", exp_data.size(), 0);

        // 2: zero-line start
        r0 = reads_seen;
        d0 = n_done;
        do_start(7'd3, 16'd0, 0);
        check("t2_done", done_o, 1);
        check("t2_busy", busy_o, 0);
        @(negedge clk_i);
        check("t2_done_once", done_o, 0);
        check("t2_busy2", busy_o, 0);
        repeat (3) @(negedge clk_i);
        check("t2_no_reads", reads_seen - r0, 0);
        check("t2_done_cnt", n_done - d0, 1);

        // 3: address wrap
        do_start(7'd126, 16'd4, 1);
        wait_done("t3_done");
        check("t3_queue", exp_data.size(), 0);

        // 4: backpressure mid-stream (also covers line 9 with -7/+9)
        b0 = n_beats;
        do_start(7'd5, 16'd10, 1);
        wait_beats(b0 + 3);
        out_ready_i = 1'b0;
        @(negedge clk_i);
        held = out_data_o;
        check("t4_valid_held", out_valid_o, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("t4_stable", out_data_o, held);
        end
        check("t4_outstanding", reads_seen - n_beats, 4);
        out_ready_i = 1'b1;
        wait_done("t4_done");
        check("t4_queue", exp_data.size(), 0);
        check("t4_beats", n_beats - b0, 10);

        // 5: reset mid-drain, then clean restart
        b0 = n_beats;
        do_start(7'd40, 16'd8, 1);
        wait_beats(b0 + 3);
        rst_ni = 1'b0;
        #1;
        check("t5_read", acc_read_o, 0);
        check("t5_valid", out_valid_o, 0);
        check("t5_last", out_last_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_done", done_o, 0);
        check("t5_data", out_data_o, 0);
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_start(7'd0, 16'd2, 1);
        wait_done("t5_done2");
        check("t5_queue", exp_data.size(), 0);

        // 6: start while busy is ignored
        r0 = reads_seen;
        d0 = n_done;
        do_start(7'd20, 16'd5, 1);
        start_i      = 1'b1;
        start_addr_i = 7'd90;
        lines_i      = 16'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done("t6_done");
        repeat (6) @(negedge clk_i);
        check("t6_reads", reads_seen - r0, 5);
        check("t6_done_cnt", n_done - d0, 1);
        check("t6_queue", exp_data.size(), 0);
        check("t6_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
